// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - Iterative multiply/divide unit with HI/LO result registers.
// Signed op[0] handling is compiled in only when MULDIV_SIGNED_EN is defined.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             dz;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             op_signed;
    logic             a_neg_in;
    logic             b_neg_in;
    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;
    logic             dz_in;
    logic             last_step;

`ifdef MULDIV_SIGNED_EN
    assign op_signed = op[0];
`else
    logic unused_op0;
    assign op_signed  = 1'b0;
    assign unused_op0 = op[0];
`endif

    assign a_neg_in  = op_signed & a[WIDTH-1];
    assign b_neg_in  = op_signed & b[WIDTH-1];
    assign a_mag_in  = a_neg_in ? (~a + 1'b1) : a;
    assign b_mag_in  = b_neg_in ? (~b + 1'b1) : b;
    assign dz_in     = op[1] & (b == '0);
    assign last_step = (cnt == CW'(WIDTH - 1));
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = dz_in ? S_FIX : S_CALC;
            S_CALC:  if (last_step) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // One shift-add multiply step: acc_lo holds the remaining multiplier bits.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : {(WIDTH + 1){1'b0}});
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end

    // One restoring divide step: acc_hi is the partial remainder, acc_lo shifts
    // dividend bits out at the top and quotient bits in at the bottom.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    always_comb begin
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag};
        div_ge    = ~div_diff[WIDTH];
        div_hi    = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo    = {acc_lo[WIDTH-2:0], div_ge};
    end

    // Sign restoration of the magnitude results.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = (neg_a ^ neg_b) ? (~prod + 1'b1) : prod;
        quot_fix = (neg_a ^ neg_b) ? (~acc_lo + 1'b1) : acc_lo;
        rem_fix  = neg_a ? (~acc_hi + 1'b1) : acc_hi;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            is_div      <= 1'b0;
            dz          <= 1'b0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            a_raw       <= '0;
            b_mag       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_wr) hi <= wr_data;
                    if (lo_wr) lo <= wr_data;
                    if (start) begin
                        cnt         <= '0;
                        is_div      <= op[1];
                        dz          <= dz_in;
                        neg_a       <= a_neg_in;
                        neg_b       <= b_neg_in;
                        a_raw       <= a;
                        b_mag       <= b_mag_in;
                        acc_hi      <= '0;
                        acc_lo      <= a_mag_in;
                        div_by_zero <= 1'b0;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) begin
                        acc_hi <= div_hi;
                        acc_lo <= div_lo;
                    end else begin
                        acc_hi <= mul_hi;
                        acc_lo <= mul_lo;
                    end
                end
                S_FIX: begin
                    done <= 1'b1;
                    if (dz) begin
                        hi          <= a_raw;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - Directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_wr = 1'b0;
    logic        lo_wr = 1'b0;
    logic [31:0] wr_data = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int miscompares = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called just after the start edge; counts edges until done is seen.
    task automatic wait_done(output int edges, output logic busy_ok);
        edges = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && edges < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int   edges;
        logic busy_ok;
        launch(o, x, y);
        wait_done(edges, busy_ok);
        check({tag, "_latency"}, 32'(edges), 32'(lat));
        check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int   edges;
        logic busy_ok;
        int   done_seen;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_dz", {31'd0, div_by_zero}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("multu_ffff_x2", 2'b00, 32'hFFFF_FFFF, 32'd2, 33, 32'h0000_0001, 32'hFFFF_FFFE);
`ifdef MULDIV_SIGNED_EN
        run_op("mult_m3_x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("div_m7_by2", 2'b11, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_minneg_by_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000);
`else
        run_op("mult_m3_x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 33, 32'h0000_0004, 32'hFFFF_FFF1);
        run_op("div_m7_by2", 2'b11, 32'hFFFF_FFF9, 32'd2, 33, 32'h0000_0001, 32'h7FFF_FFFC);
        run_op("div_minneg_by_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'h0000_0000);
`endif
        run_op("divu_100_by7", 2'b10, 32'd100, 32'd7, 33, 32'd2, 32'd14);

        // Divide by zero skips CALC and holds div_by_zero until the next start.
        run_op("divu_by0", 2'b10, 32'd7, 32'd0, 1, 32'd7, 32'hFFFF_FFFF);
        repeat (5) @(posedge clk);
        #1;
        check("dz_held", {31'd0, div_by_zero}, 32'd1);
        launch(2'b00, 32'd3, 32'd3);
        check("dz_cleared_on_start", {31'd0, div_by_zero}, 32'd0);
        wait_done(edges, busy_ok);
        check("multu_3x3_lo", lo, 32'd9);

        // Start and hi_wr while busy are ignored.
        launch(2'b10, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5; hi_wr = 1'b1; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; hi_wr = 1'b0;
        #6;
        check("busy_hiwr_ignored", hi, 32'd9 >> 32);
        wait_done(edges, busy_ok);
        check("ignore_latency", 32'(edges + 5), 32'd33);
        check("ignore_hi", hi, 32'd2);
        check("ignore_lo", lo, 32'd14);
        @(posedge clk); #1;
        check("ignore_no_second_op", {31'd0, busy}, 32'd0);

        // Direct write while idle.
        @(negedge clk);
        hi_wr = 1'b1; wr_data = 32'h0000_1234;
        @(posedge clk); #1;
        hi_wr = 1'b0;
        check("idle_hi_wr", hi, 32'h0000_1234);
        check("idle_hi_wr_lo_kept", lo, 32'd14);

        // Simultaneous start and lo_wr: write lands first, result overwrites it.
        @(negedge clk);
        op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1; lo_wr = 1'b1; wr_data = 32'h0000_AAAA;
        @(posedge clk); #1;
        start = 1'b0; lo_wr = 1'b0;
        check("start_lo_wr_lo", lo, 32'h0000_AAAA);
        wait_done(edges, busy_ok);
        check("start_lo_wr_result", lo, 32'd42);
        check("start_lo_wr_hi", hi, 32'd0);

        // Reset in the middle of CALC aborts the operation silently.
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || hi !== 32'd0 || lo !== 32'd0) done_seen++;
        end
        check("abort_no_done_no_update", 32'(done_seen), 32'd0);
        run_op("after_reset_divu", 2'b10, 32'd1000, 32'd10, 33, 32'd0, 32'd100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand width (even, >= 4).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port: op  input  2  00 multu, 01 mult, 10 divu, 11 div.
REQ-006 SHALL have port: a  input  WIDTH  multiplicand / dividend.
REQ-007 SHALL have port: b  input  WIDTH  multiplier / divisor.
REQ-008 SHALL have port: hi_wr, lo_wr  input  1 each  direct write of HI/LO (mthi/mtlo).
REQ-009 SHALL have port: wr_data  input  WIDTH  data for hi_wr/lo_wr.
REQ-010 SHALL have port: busy  output  1  operation in progress.
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: div_by_zero  output  1  last accepted divide had b == 0.
REQ-013 SHALL have port: hi, lo  output  WIDTH each  HI/LO result registers.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> FIX -> IDLE; divide-by-zero path IDLE -> FIX.
REQ-015 SHALL accept start on edge E when in IDLE; a, b, op latched at E; busy=1 from E until the edge that sets done.
REQ-016 SHALL run CALC for exactly WIDTH cycles: shift-add multiply, restoring divide, one bit per cycle, via an internal cycle counter.
REQ-017 SHALL, for a non-zero-divisor operation, update hi/lo and set done=1 on edge E+WIDTH+1; done SHALL clear on the next edge.
REQ-018 SHALL, for multiply, write hi = product[2*WIDTH-1:WIDTH] and lo = product[WIDTH-1:0].
REQ-019 SHALL, for divide, write lo = quotient and hi = remainder.
REQ-020 SHALL, for a divide with b == 0, bypass CALC: on edge E+1 set hi=a, lo=all ones, div_by_zero=1, done=1.
REQ-021 SHALL hold div_by_zero until the next accepted start, which clears it.
REQ-022 SHALL ignore start while busy; no queuing.
REQ-023 SHALL ignore hi_wr/lo_wr while busy.
REQ-024 SHALL, when idle, load hi/lo from wr_data on the edge hi_wr/lo_wr is high.
REQ-025 SHALL, on simultaneous start and hi_wr/lo_wr in IDLE, perform both; the operation result later overwrites hi/lo.
REQ-026 SHALL hold hi/lo unchanged between completions and direct writes.

Reset
REQ-027 SHALL, on reset assertion at any time including mid-operation, immediately force IDLE, counter=0, busy=0, done=0, div_by_zero=0, hi=0, lo=0.
REQ-028 SHALL NOT produce a done pulse or any hi/lo update for an operation aborted by reset.

Configuration
REQ-029 SHALL support macro MULDIV_SIGNED_EN.
REQ-030 SHALL, when MULDIV_SIGNED_EN is defined, treat op[0]=1 as signed two's complement:
- operate on magnitudes, then negate in FIX;
- product sign = sign(a) XOR sign(b);
- quotient sign = sign(a) XOR sign(b);
- remainder sign = sign(a);
- most-negative / -1 SHALL yield lo = most-negative, hi = 0.
REQ-031 SHALL, when MULDIV_SIGNED_EN is undefined, ignore op[0]; all operations unsigned with identical latency.

Verification (WIDTH=32, MULDIV_SIGNED_EN defined unless noted)
REQ-032 SHALL cover: multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE, done pulse exactly 33 edges after start edge, busy high throughout.
REQ-033 SHALL cover: mult a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; same run without macro -> hi=0x00000004, lo=0xFFFFFFF1.
REQ-034 SHALL cover: div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=100, b=7 -> lo=14, hi=2.
REQ-035 SHALL cover: divu a=7, b=0 -> done 1 edge after start, hi=7, lo=0xFFFFFFFF, div_by_zero=1 until next start.
REQ-036 SHALL cover: reset pulsed at CALC cycle 10 -> busy=0, hi=lo=0, no done for aborted op; a start after reset completes normally.
REQ-037 SHALL cover: start and hi_wr pulsed while busy -> both ignored, original result delivered; hi_wr with 0x1234 while idle -> hi=0x1234 next cycle.
